validador_combinacion: RTL
==========================

// Module: validador_combinacion
// PURPOSE
//  Sequential front-end for the 22-value 6-bit membership comparator. Captures 6-bit
//  entries on a strobe, drives the registered entry to the comparator, samples the
//  comparator's membership flag and accepts a combination after N consecutive members,
//  each entered within a timeout window. Sits directly upstream of the comparator.
// PARAMETERS
//  N        4   consecutive member entries needed for acceptance (>=1)
//  TIMEOUT  16  max cycles waited in S_WAIT for the next entry (>=2)
//  HOLD     2   cycles Aceptado/Rechazado stay high (>=1)
// PORTS
//  Reloj        in   1  single clock, all state on rising edge
//  Reset        in   1  synchronous, active-high
//  Dato         in   6  entry value
//  Dato_Valido  in   1  1-cycle entry strobe, honoured only when Listo=1
//  Pertenece    in   1  comparator output, combinational function of Dato_Reg
//  Dato_Reg     out  6  registered entry, wired to the comparator input
//  Listo        out  1  1 in S_IDLE/S_WAIT: block can take an entry
//  Aceptado     out  1  high HOLD cycles after N-th consecutive member
//  Rechazado    out  1  high HOLD cycles after a non-member, timeout or (opt) repeat
//  Conteo       out  $clog2(N+1)  members accepted in current attempt
// BEHAVIOUR
//  Reset (sync, wins over all): state=S_IDLE, Dato_Reg=0, Conteo=0, timer=0,
//   Aceptado=0, Rechazado=0, Listo=1. Mid-attempt reset aborts without a Rechazado pulse.
//  Outputs are registered, except Listo, which is decoded from state.
//  FSM:
//   S_IDLE: Dato_Valido -> Dato_Reg<=Dato, go S_EVAL.
//   S_EVAL (exactly 1 cycle; Pertenece valid here, 1 cycle after capture):
//    Pertenece=1 and Conteo+1==N -> Conteo<=N, go S_OK.
//    Pertenece=1 otherwise       -> Conteo<=Conteo+1, timer<=0, go S_WAIT.
//    Pertenece=0                 -> go S_FAIL.
//   S_WAIT: timer increments each cycle. Dato_Valido -> capture, go S_EVAL. This takes
//    priority when timer==TIMEOUT-1 in the same cycle. Else timer==TIMEOUT-1 -> S_FAIL.
//   S_OK:   Aceptado=1 for HOLD cycles. Then Conteo<=0, go S_IDLE.
//   S_FAIL: Rechazado=1 for HOLD cycles. Conteo<=0 on entry. Then go S_IDLE.
//  Dato_Valido while Listo=0 is dropped: no buffering, Dato_Reg unchanged.
//  Dato_Reg holds its value until the next capture. It is never cleared by S_OK/S_FAIL.
//  Aceptado and Rechazado are never high together. Conteo never exceeds N.
//  Latency: strobe at cycle t -> Dato_Reg at t+1, decision in S_EVAL at t+1,
//   Aceptado/Rechazado first high at t+2.
//  N=1: first member goes straight to S_OK. S_WAIT is never entered.
// CONFIGURATION
//  REPETIDO_RECHAZO_EN defined: adds a 6-bit register Ultimo, loaded with Dato_Reg on
//   every accepted member and reset to 0. In S_EVAL, if Conteo>0 and Dato_Reg==Ultimo,
//   go S_FAIL even when Pertenece=1.
//  Undefined: no Ultimo register. Repeated member values count normally.
// TESTING (N=4, TIMEOUT=16, HOLD=2; bench models the comparator set)
//  1. Strobes 1,2,3,5 with 3 idle cycles between each -> Conteo 1,2,3,4.
//     Aceptado high 2 cycles starting 2 cycles after the 4th strobe. Then Conteo=0, Listo=1.
//  2. Strobes 10 then 4 (000_100, not a member) -> Conteo=1, then Rechazado for 2 cycles.
//     Aceptado stays 0. Conteo=0 afterwards.
//  3. Strobe 20, then no strobe -> Rechazado rises 16 cycles after S_WAIT entry.
//     A strobe at timer==15 instead is captured with no rejection.
//  4. Strobe during S_EVAL/S_OK/S_FAIL -> ignored. Dato_Reg and Conteo unchanged.
//  5. Reset asserted with Conteo=3 in S_WAIT -> next cycle all outputs at reset values.
//     No Rechazado pulse.
//  6. REPETIDO_RECHAZO_EN: strobes 21,21 -> Rechazado. Without the macro -> Conteo=2.

Source files
------------

// File: rtl/validador_combinacion.sv
// validador_combinacion: sequential front-end for the 6-bit membership comparator.
// Captures an entry on Dato_Valido, exposes it on Dato_Reg and samples Pertenece one
// cycle later. It accepts a combination after N consecutive members, with each entry
// arriving within TIMEOUT cycles of the previous one. Aceptado and Rechazado each stay
// high for HOLD cycles.
// Optional build macro REPETIDO_RECHAZO_EN: rejects a member equal to the previously
// accepted member of the same attempt.
module validador_combinacion #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int HOLD    = 2
) (
  input  logic                     Reloj,
  input  logic                     Reset,
  input  logic [5:0]               Dato,
  input  logic                     Dato_Valido,
  input  logic                     Pertenece,
  output logic [5:0]               Dato_Reg,
  output logic                     Listo,
  output logic                     Aceptado,
  output logic                     Rechazado,
  output logic [$clog2(N+1)-1:0]   Conteo
);

  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] N_VAL  = CW'(N);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_WAIT,
    S_OK,
    S_FAIL
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_next;
  logic [CW-1:0]   conteo_next;
  logic [5:0]      dato_reg_next;
  logic            aceptado_next;
  logic            rechazado_next;
  logic            repetido;
  logic            miembro_ok;
  logic            hold_done;

`ifdef REPETIDO_RECHAZO_EN
  logic [5:0]      ultimo;
  logic [5:0]      ultimo_next;

  // A member identical to the last accepted one in this attempt counts as a failure
  assign repetido = (Conteo != '0) && (Dato_Reg == ultimo);
`else
  assign repetido = 1'b0;
`endif

  assign miembro_ok = Pertenece && !repetido;
  assign hold_done  = (hold_cnt == H_LAST);

  // Listo is decoded directly from state so a strobe is honoured only in IDLE/WAIT
  assign Listo = (state == S_IDLE) || (state == S_WAIT);

  // State register; reset returns to IDLE without emitting a rejection pulse
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision: EVAL always lasts one cycle, OK/FAIL last HOLD cycles
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (Dato_Valido) state_next = S_EVAL;
      end
      S_EVAL: begin
        if (!miembro_ok)               state_next = S_FAIL;
        else if (Conteo + 1'b1 == N_VAL) state_next = S_OK;
        else                           state_next = S_WAIT;
      end
      S_WAIT: begin
        if (Dato_Valido)          state_next = S_EVAL;
        else if (timer == T_LAST) state_next = S_FAIL;
      end
      S_OK: begin
        if (hold_done) state_next = S_IDLE;
      end
      S_FAIL: begin
        if (hold_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters, derived from the transition
  always_comb begin
    dato_reg_next  = Dato_Reg;
    conteo_next    = Conteo;
    timer_next     = '0;
    hold_next      = '0;
`ifdef REPETIDO_RECHAZO_EN
    ultimo_next    = ultimo;
`endif
    if (Listo && Dato_Valido) begin
      dato_reg_next = Dato;
    end
    if (state == S_EVAL && miembro_ok) begin
      conteo_next = Conteo + 1'b1;
`ifdef REPETIDO_RECHAZO_EN
      ultimo_next = Dato_Reg;
`endif
    end
    if (state_next == S_FAIL) begin
      conteo_next = '0;
    end
    if (state == S_OK && state_next == S_IDLE) begin
      conteo_next = '0;
    end
    if (state == S_WAIT) begin
      timer_next = timer + 1'b1;
    end
    if (state == S_OK || state == S_FAIL) begin
      hold_next = hold_cnt + 1'b1;
    end
    aceptado_next  = (state_next == S_OK);
    rechazado_next = (state_next == S_FAIL);
  end

  // Datapath registers: entry, attempt count, wait timer, pulse length and flags
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      Dato_Reg  <= '0;
      Conteo    <= '0;
      timer     <= '0;
      hold_cnt  <= '0;
      Aceptado  <= 1'b0;
      Rechazado <= 1'b0;
`ifdef REPETIDO_RECHAZO_EN
      ultimo    <= '0;
`endif
    end else begin
      Dato_Reg  <= dato_reg_next;
      Conteo    <= conteo_next;
      timer     <= timer_next;
      hold_cnt  <= hold_next;
      Aceptado  <= aceptado_next;
      Rechazado <= rechazado_next;
`ifdef REPETIDO_RECHAZO_EN
      ultimo    <= ultimo_next;
`endif
    end
  end

endmodule
